// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks: decoder FSM states and
// default widths matching the neuron's 8-bit parameters.
package snn_pkg;
  localparam int SPIKE_CNT_W = 8;
  localparam int WIN_W       = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;
endpackage

// File: rtl/rate_out_reg.sv
// One-entry valid/ready result register. A result that arrives while the entry
// is full and not being consumed is dropped and flagged on a sticky overrun.
module rate_out_reg #(
  parameter int RATE_W = 8,
  parameter int LAT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [RATE_W-1:0] load_rate,
  input  logic [LAT_W-1:0]  load_lat,
  input  logic              ready,
  output logic [RATE_W-1:0] rate,
  output logic [LAT_W-1:0]  latency,
  output logic              valid,
  output logic              overrun
);
  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; rate/latency never change while valid is high unless that same
  // edge is a transfer.
  logic xfer;
  assign xfer = valid & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate    <= '0;
      latency <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (load) begin
      if (!valid || xfer) begin
        rate    <= load_rate;
        latency <= load_lat;
        valid   <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder for one LIF neuron: counts spikes and first-spike latency over
// a window of enabled cycles and hands the result to a valid/ready register.
module spike_rate_decoder #(
  parameter int WIN_W = snn_pkg::WIN_W,
  parameter int CNT_W = snn_pkg::SPIKE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic [WIN_W-1:0] latency_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output snn_pkg::state_t  state_dbg
);
  import snn_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] ONE_W   = WIN_W'(1);

  state_t state, state_nxt;

  logic [WIN_W-1:0] win_l, cyc, lat;
  logic [CNT_W-1:0] cnt;
  logic             seen;

  logic [WIN_W-1:0] cur_l, idx, lat_prev, lat_new, res_lat;
  logic [CNT_W-1:0] cnt_prev, cnt_new;
  logic             seen_prev, seen_new, last;

  // In IDLE the current enabled cycle is window cycle 1 of a fresh window, so
  // the accumulators start from zero and L comes straight from window_len.
  always_comb begin
    cur_l     = win_l;
    idx       = cyc + ONE_W;
    cnt_prev  = cnt;
    lat_prev  = lat;
    seen_prev = seen;
    if (state == IDLE) begin
      cur_l     = (window_len == '0) ? ONE_W : window_len;
      idx       = ONE_W;
      cnt_prev  = '0;
      lat_prev  = '0;
      seen_prev = 1'b0;
    end
    cnt_new  = (spike_in && (cnt_prev != CNT_MAX)) ? cnt_prev + CNT_W'(1) : cnt_prev;
    seen_new = seen_prev | spike_in;
    lat_new  = (spike_in && !seen_prev) ? idx : lat_prev;
    res_lat  = seen_new ? lat_new : cur_l;
    last     = enable && (idx == cur_l);
  end

  always_comb begin
    state_nxt = state;
    if (enable) begin
      state_nxt = last ? IDLE : COUNT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Window accumulators only advance on enabled cycles; the final cycle hands
  // its result to the output register and leaves them for IDLE to reseed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_l <= '0;
      cyc   <= '0;
      cnt   <= '0;
      lat   <= '0;
      seen  <= 1'b0;
    end else if (enable && !last) begin
      win_l <= cur_l;
      cyc   <= idx;
      cnt   <= cnt_new;
      lat   <= lat_new;
      seen  <= seen_new;
    end
  end

  rate_out_reg #(
    .RATE_W(CNT_W),
    .LAT_W (WIN_W)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (last),
    .load_rate(cnt_new),
    .load_lat (res_lat),
    .ready    (rate_ready),
    .rate     (rate_out),
    .latency  (latency_out),
    .valid    (rate_valid),
    .overrun  (overrun)
  );

  assign state_dbg = state;
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receiving end of the neuron spike interface: turns a `spike_out` train into a rate value.
- Counts spikes from one LIF neuron over a programmable window of enabled cycles.
- Reports count and first-spike latency through a valid/ready output register.
- Sits between the neuron array and downstream classification logic; it is the decoder for the current-to-spike encoding done by the neuron.

Parameters:
- `WIN_W`, 8, width of `window_len` and of the internal cycle counter.
- `CNT_W`, 8, width of the spike count; the count saturates at 2^CNT_W-1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  qualifies each cycle; low freezes all window state.
- `spike_in`  in  1  spike from neuron, one bit per cycle.
- `window_len`  in  WIN_W  window length in enabled cycles; latched at window start.
- `rate_out`  out  CNT_W  spike count of the last completed window.
- `latency_out`  out  WIN_W  enabled cycles from window start to the first spike.
- `rate_valid`  out  1  output register holds an unconsumed result.
- `rate_ready`  in  1  consumer accepts the result.
- `overrun`  out  1  sticky flag: a completed window was dropped.

Behaviour:
- Reset (async, any time, including mid-window):
  - state=IDLE.
  - `rate_out`=0, `latency_out`=0, `rate_valid`=0, `overrun`=0.
  - Internal counters cleared.
- States:
  - IDLE: on a cycle with `enable`=1, latch L=max(`window_len`,1), go to COUNT, and count that cycle as window cycle 1, including its `spike_in`.
  - COUNT: each `enable`=1 cycle advances `cyc` 1..L. When `enable`=0, `cyc`, `cnt`, `lat` and the first-seen flag hold; `spike_in` is ignored.
- Count: `cnt` increments on `spike_in`=1 and saturates at 2^CNT_W-1, never wrapping.
- Latency: `lat` = `cyc` index of the first spike in the window, 1-based. If no spike occurs, `lat`=L.
- Window end:
  - The edge that samples cycle L (the spike on cycle L is included) produces result {`cnt`,`lat`}.
  - `rate_valid` rises the following cycle, so latency is 1 cycle after the last window cycle.
  - Next window starts back-to-back on the next enabled cycle with a fresh L from `window_len`; no IDLE gap.
- Output handshake:
  - A transfer occurs when `rate_valid`=1 and `rate_ready`=1.
  - `rate_out` and `latency_out` are stable while `rate_valid`=1.
  - After a transfer with no new result, `rate_valid` goes to 0 the next cycle.
- Result arriving at the output register:
  - Register empty: load the result, set `rate_valid`=1.
  - Register full and transfer in the same cycle: load the new result, `rate_valid` stays 1.
  - Register full and no transfer: drop the new result, keep the old one, set `overrun`=1.
- `overrun` clears only on reset.
- `window_len` changes mid-window have no effect until the next window start.
- `rate_ready` is ignored while `rate_valid`=0.

Decomposition:
- Shared package `snn_pkg`:
  - state enum {IDLE, COUNT}.
  - default widths `SPIKE_CNT_W`=8 and `WIN_W`=8, shared with the neuron's 8-bit parameters.
- One natural sub-module, `rate_out_reg`: a one-entry valid/ready holding register with drop-on-full and a sticky `overrun` output.
- Window counting stays in the top module.

Test Plan:
- Window and timing: `window_len`=10, `spike_in` high on window cycles 3, 5 and 10, `rate_ready`=1 → `rate_out`=3, `latency_out`=3; `rate_valid` is a 1-cycle pulse one cycle after window cycle 10.
- Enable gating: `window_len`=8, `spike_in`=1 every cycle, `enable` low for 5 cycles mid-window → `rate_out`=8, `rate_valid` is delayed by exactly 5 cycles, and no spikes are counted while disabled.
- Saturation and empty window:
  - `window_len`=255 with constant spikes, `CNT_W`=4 → `rate_out`=15, no wrap.
  - A window with no spikes → `rate_out`=0, `latency_out`=255.
- Backpressure:
  - `window_len`=4, `rate_ready`=0 for 10 cycles → first result held, second dropped, `overrun`=1.
  - Then `rate_ready`=1 → the held result transfers; `overrun` stays 1.
- Simultaneous transfer and load: `rate_ready` asserted exactly on the cycle a new result arrives → new value loaded, `rate_valid` stays 1, `overrun`=0.
- Reset and zero length:
  - `reset` pulsed mid-window for 30 ns → all outputs 0 immediately (asynchronous), FSM returns to IDLE.
  - `window_len`=0 → behaves as L=1, giving one result per enabled cycle equal to `spike_in`.
